imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Byte-stream program loader sitting directly upstream of the RV32 core's instruction memory.
//  Consumes bytes from a UART-RX style valid/ready source and packs them little-endian into 32-bit words.
//  Drives the core's insMemEn/insMemAddr/insMemData write port.
//  Holds the core in reset while loading and releases it once the image is complete.
// PARAMETERS
//  WIDTH          32     data/address width of the instruction-memory write port
//  IMEM_DEPTH     512    words in instruction memory; larger images are rejected
//  TIMEOUT_CYCLES 100000 max idle cycles between bytes once a load has started
// PORTS
//  clock      in   1      clock, rising edge
//  reset      in   1      reset, synchronous, active-high
//  rx_data    in   8      incoming byte
//  rx_valid   in   1      rx_data valid
//  rx_ready   out  1      loader accepts byte (transfer = rx_valid & rx_ready)
//  mem_we     out  1      one-cycle write strobe -> insMemEn
//  mem_addr   out  WIDTH  word index, zero-extended -> insMemAddr
//  mem_data   out  WIDTH  packed word -> insMemData
//  cpu_reset  out  1      reset to core; high while not in RUN
//  load_done  out  1      high in RUN
//  load_err   out  1      high in ERROR
// BEHAVIOUR
//  Frame: sync byte 0xA5, LEN_LO, LEN_HI (word count N, 16b), then 4*N data bytes, LSB first.
//  rx_ready=0 while reset is high, 1 otherwise. Every state accepts one byte per cycle.
//  Reset values: mem_we=0, mem_addr=0, mem_data=0, cpu_reset=1, load_done=0, load_err=0.
//  Reset also clears word_idx, byte_cnt and the timeout counter, and returns the FSM to IDLE.
//  FSM states:
//   IDLE   : byte 0xA5 -> LEN_LO; any other byte is discarded.
//   LEN_LO : latch N[7:0] -> LEN_HI.
//   LEN_HI : latch N[15:8].
//            N > IMEM_DEPTH -> ERROR.
//            N == 0 -> RUN (CSUM when the checksum is enabled).
//            Otherwise clear word_idx and byte_cnt -> DATA.
//   DATA   : byte k of a word goes into mem_data[8k+7:8k].
//            On the 4th byte (accepted cycle t): mem_we=1 in t+1 with mem_addr=word_idx, then word_idx++.
//            Last word written -> RUN (CSUM when enabled).
//            cpu_reset falls at t+2, after the last write.
//   RUN    : cpu_reset=0, load_done=1.
//            Byte 0xA5 -> LEN_LO, cpu_reset=1 and load_done=0 from the next cycle (reload).
//            Other bytes are ignored.
//   ERROR  : cpu_reset=1, load_err=1.
//            Byte 0xA5 -> LEN_LO with load_err cleared; other bytes are ignored.
//  Timeout: in LEN_LO/LEN_HI/DATA/CSUM, the counter clears on each accepted byte and increments otherwise.
//   Reaching TIMEOUT_CYCLES -> ERROR.
//  mem_addr/mem_data hold their last value when mem_we=0.
//  mem_we never asserts outside DATA+1 and never for word_idx >= N.
// CONFIGURATION
//  LOADER_CSUM_EN defined:
//   - Extra state CSUM after the last data byte.
//   - Expects one byte = sum mod 256 of all data bytes (header excluded).
//   - Match -> RUN the cycle after the byte is accepted; mismatch -> ERROR.
//  LOADER_CSUM_EN undefined: no CSUM state or sum register; DATA goes straight to RUN.
// STRUCTURE
//  loader_pkg: state enum (IDLE, LEN_LO, LEN_HI, DATA, CSUM, RUN, ERROR), SYNC_BYTE=8'hA5, LEN_W=16.
//  Sub-module loader_word_pack:
//   - Byte shift/pack into a 32-bit word, 2-bit byte_cnt, word_ready pulse.
//   - Inputs: clear and byte strobe.
//  Top level owns the FSM, word_idx, timeout counter and checksum.
// TESTING
//  1. A5 02 00 13 00 00 00 93 00 10 00, back-to-back
//     -> mem_we (addr0, 0x00000013), then (addr1, 0x00100093).
//     -> cpu_reset falls 2 cycles after the last byte; load_done=1.
//  2. 00 FF 5A before the A5 frame of test 1 -> no writes before A5; result identical to test 1.
//  3. A5 01 02 (N=513, IMEM_DEPTH=512) -> ERROR, load_err=1, cpu_reset=1, zero mem_we pulses.
//  4. A5 01 00 11 22, then idle TIMEOUT_CYCLES -> ERROR with no write.
//     Repeat, then assert reset mid-DATA -> all outputs at reset values; next frame loads normally.
//  5. After test 1 in RUN, send A5 01 00 EF BE AD DE
//     -> cpu_reset=1 the cycle after A5; write (addr0, 0xDEADBEEF); RUN again.
//  6. LOADER_CSUM_EN: A5 01 00 01 02 03 04 + 0A -> RUN.
//     Same frame with trailing 0B -> ERROR, load_err=1.

Source files
------------

// File: rtl/loader_pkg.sv
// loader_pkg
// Shared definitions for the instruction-memory boot loader:
//   state_t   - loader FSM states
//   SYNC_BYTE - byte that opens every frame
//   LEN_W     - width of the word-count field in the frame header
// No ports (package).
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        RUN,
        ERROR
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         LEN_W     = 16;

endpackage

// File: rtl/loader_word_pack.sv
// loader_word_pack
// Packs a byte stream little-endian into 32-bit words. The first byte of a
// word lands in bits [7:0], the fourth in bits [31:24]. The completed word
// is copied into an output register that holds until the next word is done,
// so downstream logic can present it as a stable write-data bus.
// Ports:
//   clock       in   1   clock, rising edge
//   reset       in   1   synchronous, active-high reset
//   clear       in   1   discard any partial word, restart at byte 0
//   byte_strobe in   1   byte_in is a data byte to pack this cycle
//   byte_in     in   8   data byte
//   word        out  32  last completed word (holds between completions)
//   byte_cnt    out  2   position of the next byte within the word
//   word_ready  out  1   one-cycle pulse the cycle after a word completes
module loader_word_pack (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_strobe,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic [1:0]  byte_cnt,
    output logic        word_ready
);

    logic [31:0] shreg;

    // Bytes shift in from the top so that after four strobes the first byte
    // has moved down to [7:0]. The fourth byte bypasses the shift register
    // and goes straight into the held output word.
    always_ff @(posedge clock) begin
        if (reset) begin
            shreg      <= '0;
            byte_cnt   <= '0;
            word       <= '0;
            word_ready <= 1'b0;
        end else begin
            word_ready <= 1'b0;
            if (clear) begin
                shreg    <= '0;
                byte_cnt <= '0;
            end else if (byte_strobe) begin
                shreg    <= {byte_in, shreg[31:8]};
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    word       <= {byte_in, shreg[31:8]};
                    word_ready <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Byte-stream program loader in front of the RV32 core's instruction memory.
// Frame: 0xA5, LEN_LO, LEN_HI (word count N), then 4*N data bytes LSB first.
// Words are written to the instruction memory one at a time, and the core is
// held in reset until the whole image has landed.
// Optional build macro: LOADER_CSUM_EN adds a trailing checksum byte (sum
// mod 256 of the data bytes) that must match before the core is released.
// Ports:
//   clock      in   1      clock, rising edge
//   reset      in   1      synchronous, active-high reset
//   rx_data    in   8      incoming byte
//   rx_valid   in   1      rx_data valid
//   rx_ready   out  1      byte accepted when rx_valid & rx_ready
//   mem_we     out  1      one-cycle instruction-memory write strobe
//   mem_addr   out  WIDTH  word index being written
//   mem_data   out  WIDTH  packed word being written
//   cpu_reset  out  1      core reset, low only once the image is loaded
//   load_done  out  1      image loaded, core running
//   load_err   out  1      frame rejected (too long, timeout, bad checksum)
module imem_boot_loader #(
    parameter int WIDTH          = 32,
    parameter int IMEM_DEPTH     = 512,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_data,
    output logic             cpu_reset,
    output logic             load_done,
    output logic             load_err
);

    import loader_pkg::*;

    localparam int                 TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]    TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam int                 DEPTH_W = LEN_W + 1;
    localparam logic [DEPTH_W-1:0] DEPTH_L = DEPTH_W'(IMEM_DEPTH);

`ifdef LOADER_CSUM_EN
    localparam state_t DONE_STATE = CSUM;
`else
    localparam state_t DONE_STATE = RUN;
`endif

    state_t           state, next_state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] word_idx;
    logic [TO_W-1:0]  timeout_cnt;

    logic             accept;
    logic [LEN_W-1:0] len_full;
    logic             len_too_big;
    logic             timed_state;
    logic             timeout_hit;
    logic             byte_strobe;
    logic             pack_clear;
    logic             last_byte;
    logic [31:0]      packed_word;
    logic [1:0]       byte_cnt;
    logic             word_ready;

`ifdef LOADER_CSUM_EN
    logic [7:0]       csum_q;
`endif

    assign rx_ready    = !reset;
    assign accept      = rx_valid && rx_ready;
    assign len_full    = {rx_data, len_q[7:0]};
    assign len_too_big = {1'b0, len_full} > DEPTH_L;
    assign timed_state = (state == LEN_LO) || (state == LEN_HI) ||
                         (state == DATA)   || (state == CSUM);
    assign timeout_hit = timed_state && !accept && (timeout_cnt == TO_LAST);
    assign byte_strobe = accept && (state == DATA);
    assign pack_clear  = (state != DATA);
    // Fourth byte of the final word: the FSM leaves DATA on this edge while
    // the write itself appears on mem_we in the following cycle.
    assign last_byte   = byte_strobe && (byte_cnt == 2'd3) &&
                         (word_idx == len_q - LEN_W'(1));

    loader_word_pack u_pack (
        .clock      (clock),
        .reset      (reset),
        .clear      (pack_clear),
        .byte_strobe(byte_strobe),
        .byte_in    (rx_data),
        .word       (packed_word),
        .byte_cnt   (byte_cnt),
        .word_ready (word_ready)
    );

    assign mem_we   = word_ready;
    assign mem_data = WIDTH'(packed_word);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A timeout overrides whatever the byte decode chose,
    // but it can only fire in a cycle where no byte was accepted.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept && rx_data == SYNC_BYTE) next_state = LEN_LO;
            end
            LEN_LO: begin
                if (accept) next_state = LEN_HI;
            end
            LEN_HI: begin
                if (accept) begin
                    if (len_too_big)           next_state = ERROR;
                    else if (len_full == '0)   next_state = DONE_STATE;
                    else                       next_state = DATA;
                end
            end
            DATA: begin
                if (last_byte) next_state = DONE_STATE;
            end
`ifdef LOADER_CSUM_EN
            CSUM: begin
                if (accept) next_state = (rx_data == csum_q) ? RUN : ERROR;
            end
`endif
            RUN, ERROR: begin
                if (accept && rx_data == SYNC_BYTE) next_state = LEN_LO;
            end
            default: next_state = IDLE;
        endcase
        if (timeout_hit) next_state = ERROR;
    end

    // Status outputs decoded from the current state.
    always_comb begin
        load_done = (state == RUN);
        load_err  = (state == ERROR);
    end

    // Length latch, word index, write address, idle timeout and core reset.
    // cpu_reset stays high through the cycle in which RUN is first entered,
    // so the core is released only after the final write has been issued;
    // on a reload it rises as soon as the FSM leaves RUN.
    always_ff @(posedge clock) begin
        if (reset) begin
            len_q       <= '0;
            word_idx    <= '0;
            mem_addr    <= '0;
            timeout_cnt <= '0;
            cpu_reset   <= 1'b1;
        end else begin
            cpu_reset <= (state != RUN) || (next_state != RUN);

            if (accept && state == LEN_LO) len_q[7:0]  <= rx_data;
            if (accept && state == LEN_HI) begin
                len_q[15:8] <= rx_data;
                word_idx    <= '0;
            end

            if (byte_strobe && byte_cnt == 2'd3) begin
                mem_addr <= WIDTH'(word_idx);
                word_idx <= word_idx + LEN_W'(1);
            end

            if (!timed_state || accept) timeout_cnt <= '0;
            else                        timeout_cnt <= timeout_cnt + TO_W'(1);
        end
    end

`ifdef LOADER_CSUM_EN
    // Running sum of data bytes only; restarted when the length completes.
    always_ff @(posedge clock) begin
        if (reset) begin
            csum_q <= '0;
        end else if (accept && state == LEN_HI) begin
            csum_q <= '0;
        end else if (byte_strobe) begin
            csum_q <= csum_q + rx_data;
        end
    end
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader
// Self-checking bench for imem_boot_loader. Frames are built from a payload
// queue; the expected instruction-memory writes are derived directly from
// the frame format (word w = payload bytes 4w..4w+3, little-endian) and
// compared against every mem_we pulse captured from the DUT.
module tb_imem_boot_loader;

    localparam int TIMEOUT = 40;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        cpu_reset;
    logic        load_done;
    logic        load_err;

    int checks = 0;
    int errors = 0;

    logic [7:0]  payload[$];
    logic [63:0] expWrites[$];
    logic [63:0] gotWrites[$];
    logic [7:0]  csumDelta = 8'h00;

    imem_boot_loader #(
        .WIDTH         (32),
        .IMEM_DEPTH    (512),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .cpu_reset(cpu_reset),
        .load_done(load_done),
        .load_err (load_err)
    );

    always #5 clock = ~clock;

    // Capture every write strobe seen by the instruction memory.
    always @(negedge clock) begin
        if (mem_we === 1'b1) gotWrites.push_back({mem_addr, mem_data});
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clock);
        @(negedge clock);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clock);
        #1 rx_valid = 1'b0;
    endtask

    task automatic buildPayload(input int n);
        payload.delete();
        for (int i = 0; i < 4 * n; i++) payload.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic modelWrites(input int n);
        expWrites.delete();
        for (int w = 0; w < n; w++)
            expWrites.push_back({32'(w), payload[4*w+3], payload[4*w+2],
                                 payload[4*w+1], payload[4*w]});
    endtask

    function automatic logic [7:0] payloadSum();
        int s = 0;
        foreach (payload[i]) s += int'(payload[i]);
        return 8'(s % 256);
    endfunction

    task automatic applyStimulus(input int n, input int maxGap, input bit checkReload);
        logic [15:0] len = 16'(n);
        sendByte(8'hA5, $urandom_range(0, maxGap));
        if (checkReload) begin
            @(negedge clock);
            checkOutput("reloadCpuReset", 64'(cpu_reset), 64'd1);
            checkOutput("reloadLoadDone", 64'(load_done), 64'd0);
        end
        sendByte(len[7:0], $urandom_range(0, maxGap));
        sendByte(len[15:8], $urandom_range(0, maxGap));
        foreach (payload[i]) sendByte(payload[i], $urandom_range(0, maxGap));
`ifdef LOADER_CSUM_EN
        sendByte(payloadSum() + csumDelta, $urandom_range(0, maxGap));
`endif
    endtask

    task automatic checkWrites(input string tag);
        checkOutput({tag, "WriteCount"}, 64'(gotWrites.size()), 64'(expWrites.size()));
        for (int i = 0; i < expWrites.size() && i < gotWrites.size(); i++)
            checkOutput({tag, "Write"}, gotWrites[i], expWrites[i]);
    endtask

    task automatic checkFinal(input string tag, input bit done, input bit err);
        checkOutput({tag, "LoadDone"}, 64'(load_done), 64'(done));
        checkOutput({tag, "LoadErr"}, 64'(load_err), 64'(err));
        checkOutput({tag, "CpuReset"}, 64'(cpu_reset), 64'(!done));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "RxReady"}, 64'(rx_ready), 64'd0);
        checkOutput({tag, "MemWe"}, 64'(mem_we), 64'd0);
        checkOutput({tag, "MemAddr"}, 64'(mem_addr), 64'd0);
        checkOutput({tag, "MemData"}, 64'(mem_data), 64'd0);
        checkFinal(tag, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // Reset state.
        repeat (3) @(posedge clock);
        #1 checkResetValues("reset");
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1 checkOutput("rxReadyAfterReset", 64'(rx_ready), 64'd1);

        // Two-word image, back-to-back, with write and release timing.
        $display("[TB] two-word image");
        payload = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        modelWrites(2);
        gotWrites.delete();
        applyStimulus(2, 0, 1'b0);
        @(negedge clock);
        checkOutput("lastCycle1CpuReset", 64'(cpu_reset), 64'd1);
`ifndef LOADER_CSUM_EN
        checkOutput("lastWriteWe", 64'(mem_we), 64'd1);
        checkOutput("lastWriteAddr", 64'(mem_addr), 64'd1);
        checkOutput("lastWriteData", 64'(mem_data), 64'h00100093);
`endif
        @(negedge clock);
        checkOutput("lastCycle2CpuReset", 64'(cpu_reset), 64'd0);
        checkOutput("lastCycle2LoadDone", 64'(load_done), 64'd1);
        repeat (2) @(negedge clock);
        checkWrites("twoWord");
        checkFinal("twoWord", 1'b1, 1'b0);

        // Junk ahead of the sync byte is discarded.
        $display("[TB] leading junk");
        doReset();
        gotWrites.delete();
        sendByte(8'h00, 0);
        sendByte(8'hFF, 0);
        sendByte(8'h5A, 0);
        repeat (2) @(negedge clock);
        checkOutput("junkNoWrites", 64'(gotWrites.size()), 64'd0);
        applyStimulus(2, 0, 1'b0);
        repeat (4) @(negedge clock);
        checkWrites("junk");
        checkFinal("junk", 1'b1, 1'b0);

        // Reload from RUN.
        $display("[TB] reload");
        payload = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        modelWrites(1);
        gotWrites.delete();
        applyStimulus(1, 0, 1'b1);
        repeat (4) @(negedge clock);
        checkWrites("reload");
        checkOutput("reloadData", 64'(mem_data), 64'hDEADBEEF);
        checkFinal("reload", 1'b1, 1'b0);

        // Oversized image is rejected with no writes.
        $display("[TB] oversized image");
        expWrites.delete();
        gotWrites.delete();
        sendByte(8'hA5, 0);
        sendByte(8'h01, 0);
        sendByte(8'h02, 0);
        repeat (3) @(negedge clock);
        checkWrites("tooBig");
        checkFinal("tooBig", 1'b0, 1'b1);

        // Stalled frame times out.
        $display("[TB] timeout");
        gotWrites.delete();
        sendByte(8'hA5, 0);
        sendByte(8'h01, 0);
        sendByte(8'h00, 0);
        sendByte(8'h11, 0);
        sendByte(8'h22, 0);
        repeat (TIMEOUT / 2) @(negedge clock);
        checkOutput("timeoutEarlyErr", 64'(load_err), 64'd0);
        repeat (TIMEOUT) @(negedge clock);
        checkWrites("timeout");
        checkFinal("timeout", 1'b0, 1'b1);

        // Reset in the middle of DATA, then a normal load.
        $display("[TB] reset mid-data");
        sendByte(8'hA5, 0);
        sendByte(8'h01, 0);
        sendByte(8'h00, 0);
        sendByte(8'h11, 0);
        sendByte(8'h22, 0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1 checkResetValues("midReset");
        @(negedge clock);
        reset = 1'b0;
        buildPayload(3);
        modelWrites(3);
        gotWrites.delete();
        applyStimulus(3, 2, 1'b0);
        repeat (4) @(negedge clock);
        checkWrites("afterReset");
        checkFinal("afterReset", 1'b1, 1'b0);

        // Randomized frames with gaps and ignored junk while running.
        $display("[TB] random frames");
        for (int f = 0; f < 8; f++) begin
            int n = (f == 3) ? 0 : int'($urandom_range(1, 8));
            int junk = $urandom_range(0, 3);
            buildPayload(n);
            modelWrites(n);
            gotWrites.delete();
            for (int j = 0; j < junk; j++) begin
                logic [7:0] b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h5A;
                sendByte(b, $urandom_range(0, 2));
            end
            applyStimulus(n, 2, 1'b1);
            repeat (4) @(negedge clock);
            checkWrites("random");
            checkFinal("random", 1'b1, 1'b0);
        end

`ifdef LOADER_CSUM_EN
        // Checksum byte must match the sum of the data bytes.
        $display("[TB] checksum");
        payload = '{8'h01, 8'h02, 8'h03, 8'h04};
        modelWrites(1);
        gotWrites.delete();
        csumDelta = 8'h00;
        applyStimulus(1, 0, 1'b0);
        repeat (4) @(negedge clock);
        checkWrites("csumGood");
        checkFinal("csumGood", 1'b1, 1'b0);
        gotWrites.delete();
        csumDelta = 8'h01;
        applyStimulus(1, 0, 1'b0);
        repeat (4) @(negedge clock);
        checkWrites("csumBad");
        checkFinal("csumBad", 1'b0, 1'b1);
        csumDelta = 8'h00;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
